// File: rtl/key_schedule_iter_pkg.sv
// ============================================================================
// Module  : key_schedule_iter_pkg
// Purpose : Shared widths, shift schedule, FSM state and rotate helpers for
//           the iterative DES key schedule.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package key_schedule_iter_pkg;

    localparam int CD_W   = 56;
    localparam int KEY_W  = 48;
    localparam int HALF_W = 28;
    localparam int ROUNDS = 16;

    localparam logic [1:0] SHIFT_SCHED [ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        n);
        return (x << n) | (x >> (HALF_W - int'(n)));
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        n);
        return (x >> n) | (x << (HALF_W - int'(n)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc1.sv
// ============================================================================
// Module  : pc1
// Purpose : DES Permuted Choice 1 (64-bit key -> 56-bit C/D), parity dropped.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc1
    import key_schedule_iter_pkg::*;
(
    input  logic [63:0]     key,
    output logic [CD_W-1:0] cd
);

    // Entries are DES bit numbers (1 = MSB); output entry 0 lands on the MSB.
    localparam int PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    generate
        for (genvar i = 0; i < CD_W; i++) begin : g_bit
            assign cd[CD_W-1-i] = key[64-PC1_TAB[i]];
        end
    endgenerate

    logic unused_parity;
    assign unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

endmodule

`default_nettype wire

// File: rtl/pc2.sv
// ============================================================================
// Module  : pc2
// Purpose : DES Permuted Choice 2 (56-bit C/D -> 48-bit round subkey).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc2
    import key_schedule_iter_pkg::*;
(
    input  logic [CD_W-1:0]  cd,
    output logic [KEY_W-1:0] subkey
);

    localparam int PC2_TAB [KEY_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    generate
        for (genvar i = 0; i < KEY_W; i++) begin : g_bit
            assign subkey[KEY_W-1-i] = cd[CD_W-PC2_TAB[i]];
        end
    endgenerate

    // C/D bits 9,18,22,25,35,38,43,54 are not selected by PC-2.
    logic unused_dropped;
    assign unused_dropped = ^{cd[47], cd[38], cd[34], cd[31],
                              cd[21], cd[18], cd[13], cd[2]};

endmodule

`default_nettype wire

// File: rtl/key_schedule_iter.sv
// ============================================================================
// Module  : key_schedule_iter
// Purpose : Iterative DES key schedule emitting K1..K16 (or K16..K1) one
//           subkey per valid/ready transfer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module key_schedule_iter
    import key_schedule_iter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      key_in,
    input  logic             decrypt,
    output logic [KEY_W-1:0] round_key,
    output logic [3:0]       round_idx,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             busy,
    output logic             done
);

    state_t              state;
    state_t              state_nxt;
    logic [CD_W-1:0]     cd;
    logic [CD_W-1:0]     cd0;
    logic [3:0]          cnt;
    logic                dir;
    logic                xfer;
    logic                last;
    logic [HALF_W-1:0]   c0, d0, c_cur, d_cur;
    logic [1:0]          sh_enc, sh_dec;

    pc1 u_pc1 (.key(key_in), .cd(cd0));
    pc2 u_pc2 (.cd(cd), .subkey(round_key));

    assign c0    = cd0[CD_W-1:HALF_W];
    assign d0    = cd0[HALF_W-1:0];
    assign c_cur = cd[CD_W-1:HALF_W];
    assign d_cur = cd[HALF_W-1:0];

    assign key_valid = (state == ST_RUN);
    assign busy      = key_valid;
    assign xfer      = key_valid & key_ready;
    assign last      = (cnt == 4'd15);
    assign round_idx = dir ? (4'd15 - cnt) : cnt;

    // Shift that moves the register to the next subkey in each direction.
    assign sh_enc = SHIFT_SCHED[cnt + 4'd1];
    assign sh_dec = SHIFT_SCHED[4'd15 - cnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)        state_nxt = ST_RUN;
            ST_RUN:  if (xfer && last) state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cd   <= '0;
            cnt  <= '0;
            dir  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    dir <= decrypt;
                    cnt <= '0;
                    // Decrypt begins at K16, whose C/D equals the unrotated C0/D0.
                    cd  <= decrypt ? cd0 : {rotl28(c0, 2'd1), rotl28(d0, 2'd1)};
                end
            end else if (xfer) begin
                if (last) begin
                    cnt  <= '0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + 4'd1;
                    cd  <= dir ? {rotr28(c_cur, sh_dec), rotr28(d_cur, sh_dec)}
                               : {rotl28(c_cur, sh_enc), rotl28(d_cur, sh_enc)};
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_key_schedule_iter.sv
// ============================================================================
// Module  : tb_key_schedule_iter
// Purpose : Scoreboard bench for key_schedule_iter against a table-driven
//           DES key schedule reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_schedule_iter;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [63:0] KAT_KEY   = 64'h133457799BBCDFF1;
    localparam logic [47:0] KAT_K1    = 48'h1B02EFFC7072;
    localparam logic [47:0] KAT_K16   = 48'hCB3D8B0E17F5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] key_in;
    logic        decrypt;
    logic [47:0] round_key;
    logic [3:0]  round_idx;
    logic        key_valid;
    logic        key_ready;
    logic        busy;
    logic        done;

    key_schedule_iter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .decrypt   (decrypt),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] key;
        logic [3:0]  idx;
        bit          last;
    } exp_t;

    exp_t        q[$];
    logic [47:0] ref_ks [16];
    logic [47:0] got_keys [16];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          xfers = 0;
    int          rdy_mode = 0;
    bit          exp_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Subkey r comes straight from PC-2 of C0/D0 rotated by the cumulative shift.
    function automatic void gen_keys(input logic [63:0] k);
        logic [55:0] cd0;
        logic [55:0] cdr;
        int          tot;
        for (int i = 0; i < 56; i++) cd0[55-i] = k[64-PC1[i]];
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += SH[r];
            for (int j = 0; j < 28; j++) begin
                cdr[55-j] = cd0[55 - ((j + tot) % 28)];
                cdr[27-j] = cd0[27 - ((j + tot) % 28)];
            end
            for (int i = 0; i < 48; i++) ref_ks[r][47-i] = cdr[56-PC2[i]];
        end
    endfunction

    task automatic push_seq(input bit dec);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            int r;
            r      = dec ? 15 - k : k;
            e.key  = ref_ks[r];
            e.idx  = 4'(r);
            e.last = (k == 15);
            q.push_back(e);
        end
    endtask

    // Monitor: peek while valid, pop on transfer, track the done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("done", {63'd0, done}, {63'd0, exp_done});
            exp_done = 0;
            if (key_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("extra_key_valid", {63'd0, key_valid}, 64'd0);
                end else begin
                    e = q[0];
                    chk("round_key", {16'd0, round_key}, {16'd0, e.key});
                    chk("round_idx", {60'd0, round_idx}, {60'd0, e.idx});
                    if (key_ready === 1'b1) begin
                        void'(q.pop_front());
                        if (xfers < 16) got_keys[xfers] = round_key;
                        xfers++;
                        exp_done = e.last;
                    end
                end
            end
        end
    end

    // Backpressure driver: 0 = always ready, 1 = random stalls (runs >= 5), 2 = held low.
    initial begin
        int lowrun;
        lowrun    = 0;
        key_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: key_ready = 1'b1;
                2: key_ready = 1'b0;
                default: begin
                    if (lowrun > 0) begin
                        key_ready = 1'b0;
                        lowrun--;
                    end else if ($urandom_range(0, 5) == 0) begin
                        lowrun    = $urandom_range(4, 7);
                        key_ready = 1'b0;
                    end else begin
                        key_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Called at a negedge while the DUT is idle (or on its done cycle).
    task automatic start_seq(input logic [63:0] k, input bit dec);
        gen_keys(k);
        push_seq(dec);
        xfers   = 0;
        key_in  = k;
        decrypt = dec;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        key_in  = {$urandom, $urandom};
        decrypt = 1'($urandom);
        @(negedge clk);
        chk("first_valid_latency", {63'd0, key_valid}, 64'd1);
        chk("busy_in_run", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 2000) chk("done_timeout", 64'd1, 64'd0);
        chk("queue_drained", 64'(q.size()), 64'd0);
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_valid", {63'd0, key_valid}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        int guard;
        logic [63:0] k;
        rst      = 1'b1;
        start    = 1'b0;
        key_in   = '0;
        decrypt  = 1'b0;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {63'd0, key_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_idx", {60'd0, round_idx}, 64'd0);
        chk("rst_key", {16'd0, round_key}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer encrypt, no backpressure.
        start_seq(KAT_KEY, 1'b0);
        wait_done(cyc);
        chk("enc_cycles_to_done", 64'(cyc), 64'd16);
        chk("enc_first_key", {16'd0, got_keys[0]}, {16'd0, KAT_K1});
        chk("enc_last_key", {16'd0, got_keys[15]}, {16'd0, KAT_K16});
        idle_check();

        // Known-answer decrypt.
        start_seq(KAT_KEY, 1'b1);
        wait_done(cyc);
        chk("dec_cycles_to_done", 64'(cyc), 64'd16);
        chk("dec_first_key", {16'd0, got_keys[0]}, {16'd0, KAT_K16});
        chk("dec_last_key", {16'd0, got_keys[15]}, {16'd0, KAT_K1});
        idle_check();

        // Random keys and directions with random stalls.
        rdy_mode = 1;
        for (int n = 0; n < 6; n++) begin
            k = {$urandom, $urandom};
            start_seq(k, 1'($urandom));
            wait_done(cyc);
            idle_check();
        end

        // start during RUN with a different key must be ignored.
        k = {$urandom, $urandom};
        start_seq(k, 1'b0);
        repeat (4) @(negedge clk);
        key_in  = ~k;
        decrypt = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_done(cyc);
        idle_check();

        // Reset after the 7th transfer abandons the run without done.
        rdy_mode = 0;
        start_seq({$urandom, $urandom}, 1'b1);
        guard = 0;
        while (xfers < 7 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 200) chk("seventh_xfer_timeout", 64'd1, 64'd0);
        rdy_mode = 2;
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", {63'd0, key_valid}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_idx", {60'd0, round_idx}, 64'd0);
        q.delete();
        rdy_mode = 0;
        @(negedge clk);
        start_seq({$urandom, $urandom}, 1'b0);
        wait_done(cyc);
        chk("post_rst_cycles", 64'(cyc), 64'd16);

        // Back-to-back: each new start lands on the done cycle.
        start_seq({$urandom, $urandom}, 1'b1);
        wait_done(cyc);
        start_seq({$urandom, $urandom}, 1'b0);
        wait_done(cyc);
        rdy_mode = 1;
        start_seq({$urandom, $urandom}, 1'b1);
        wait_done(cyc);
        idle_check();
        repeat (3) @(negedge clk);
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_schedule_iter.md
KEY_SCHEDULE_ITER -- requirements
Module: key_schedule_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: a load request, sampled only in IDLE.
REQ-004 SHALL have port key_in, input, 64 bits: the DES key with parity bits, bit 63 = DES bit 1; sampled when start is accepted.
REQ-005 SHALL have port decrypt, input, 1 bit: the direction, sampled when start is accepted; 0 = K1..K16 order, 1 = K16..K1 order.
REQ-006 SHALL have port round_key, output, 48 bits: the current subkey in PC-2 order.
REQ-007 SHALL have port round_idx, output, 4 bits: the 0-based DES round number of round_key (0 = K1, 15 = K16).
REQ-008 SHALL have port key_valid, output, 1 bit: round_key and round_idx are valid.
REQ-009 SHALL have port key_ready, input, 1 bit: consumer backpressure; a transfer occurs on key_valid & key_ready.
REQ-010 SHALL have port busy, output, 1 bit: high in RUN.
REQ-011 SHALL have port done, output, 1 bit: a one-cycle pulse after the 16th transfer.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and RUN.
REQ-013 In IDLE with start=1, SHALL load the 56-bit C/D register as follows, and enter RUN on the next cycle:
- encrypt: ROL1(C0), ROL1(D0);
- decrypt: C0, D0 unrotated.
Here C0/D0 = PC-1(key_in) halves [55:28] and [27:0].
REQ-014 SHALL drive key_valid high from the first cycle after start acceptance, giving a load-to-first-key latency of 1 cycle.
REQ-015 SHALL drive round_key = PC-2(C,D register) combinationally from registered state only, so it is stable while key_valid & !key_ready.
REQ-016 Shift schedule S[0..15] SHALL be 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; each half rotates independently within 28 bits.
REQ-017 Encrypt: on the transfer of output k (k=0..14), SHALL rotate C and D left by S[k+1]; round_idx = k.
REQ-018 Decrypt: on the transfer of output k (k=0..14), SHALL rotate C and D right by S[15-k]; round_idx = 15-k.
REQ-019 SHALL hold the C/D register, the counter and the outputs unchanged on a cycle with no transfer.
REQ-020 On the transfer of output 15, SHALL deassert key_valid next cycle, pulse done for exactly one cycle, and return to IDLE.
REQ-021 SHALL ignore start while in RUN, including the cycle of the final transfer; a new start is honoured from the IDLE cycle where done is high.
REQ-022 SHALL wrap the output counter only via return to IDLE; no 17th key shall ever be emitted.
REQ-023 After 16 encrypt rotations the register SHALL equal C0/D0 (total shift 28); decrypt starts from that identity.

Reset
REQ-024 rst SHALL put the FSM in IDLE and force key_valid=0, busy=0, done=0, round_idx=0 and the C/D register to 0, so round_key = PC-2(0) = 0.
REQ-025 rst SHALL take priority over start and over any transfer, abandoning a sequence mid-run without a done pulse.

Structure
REQ-026 A shared package SHALL hold the shift schedule S (a 16-entry constant), the FSM state enum, and the widths 56, 48 and 28.
REQ-027 SHALL reuse the existing pc1 and pc2 modules as the only sub-modules; the rotation logic is local.

Verification
REQ-028 Encrypt, key 133457799BBCDFF1, key_ready=1 -> transfers on the 16 cycles after start; first round_key=1B02EFFC7072 idx 0; last=CB3D8B0E17F5 idx 15; done on the cycle after the last transfer.
REQ-029 Decrypt, same key -> first round_key=CB3D8B0E17F5 idx 15; last=1B02EFFC7072 idx 0; all 16 keys equal the encrypt list reversed.
REQ-030 Random key_ready stalls (at least 5 consecutive low cycles) -> round_key and idx held; the sequence is identical to the no-stall case.
REQ-031 start pulsed during RUN with a different key -> ignored; the original sequence completes unchanged.
REQ-032 rst asserted after the 7th transfer -> next cycle key_valid=0, busy=0, no done; a new start produces a full, correct 16-key sequence.
REQ-033 Back-to-back: start asserted on the done cycle -> a second sequence begins with key_valid 1 cycle later, with no lost or duplicated keys.
